// File: rtl/field_mem.sv
// Double-buffered Life cell storage: combinational neighbourhood lookup from the
// read bank, simulation writes into the other bank, UI load/display, row-wise clear.
module field_mem #(
  parameter  int FIELD_W    = 5,
  parameter  int FIELD_H    = 3,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cur_read_field,
  input  logic                  i_is_simulating,
  input  logic [X_ADR_SIZE-1:0] i_cur_x,
  input  logic [Y_ADR_SIZE-1:0] i_cur_y,
  input  logic                  i_new_cur_cell_state,
  input  logic [X_ADR_SIZE-1:0] i_next_x,
  input  logic [Y_ADR_SIZE-1:0] i_next_y,
  output logic                  o_next_cell_state,
  output logic [7:0]            o_next_nbrs,
  input  logic                  i_load_we,
  input  logic [X_ADR_SIZE-1:0] i_load_x,
  input  logic [Y_ADR_SIZE-1:0] i_load_y,
  input  logic                  i_load_val,
  input  logic [X_ADR_SIZE-1:0] i_disp_x,
  input  logic [Y_ADR_SIZE-1:0] i_disp_y,
  output logic                  o_disp_cell,
  input  logic                  i_clear,
  output logic                  o_busy
);
  localparam int N  = FIELD_W * FIELD_H;
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                  state_q;
  logic [Y_ADR_SIZE-1:0]   row_q;
  logic                    busy_q, disp_q;
  logic [1:0][N-1:0]       bank_q, bank_d;
  logic [N-1:0]            rb;
  int                      nx, ny, xm, xp, ym, yp;

  // Cell index is row-major: y*FIELD_W + x; out-of-range reads as dead.
  function automatic logic cell_at(input logic [N-1:0] b, input int x, input int y);
    if (x < 0 || x >= FIELD_W || y < 0 || y >= FIELD_H) return 1'b0;
    return b[IW'(y * FIELD_W + x)];
  endfunction

  function automatic logic in_range(input int x, input int y);
    return (x < FIELD_W) && (y < FIELD_H);
  endfunction

  always_comb begin
    rb                = bank_q[i_cur_read_field];
    nx                = int'(i_next_x);
    ny                = int'(i_next_y);
    xm                = (nx == 0) ? FIELD_W - 1 : nx - 1;
    xp                = (nx == FIELD_W - 1) ? 0 : nx + 1;
    ym                = (ny == 0) ? FIELD_H - 1 : ny - 1;
    yp                = (ny == FIELD_H - 1) ? 0 : ny + 1;
    o_next_cell_state = 1'b0;
    o_next_nbrs       = 8'h00;
    if (in_range(nx, ny)) begin
      o_next_cell_state = cell_at(rb, nx, ny);
      o_next_nbrs = {cell_at(rb, xp, yp), cell_at(rb, nx, yp), cell_at(rb, xm, yp),
                     cell_at(rb, xp, ny), cell_at(rb, xm, ny),
                     cell_at(rb, xp, ym), cell_at(rb, nx, ym), cell_at(rb, xm, ym)};
    end
  end

  // Clear beats everything; simulation beats load.
  always_comb begin
    bank_d = bank_q;
    if (state_q == CLEARING) begin
      for (int x = 0; x < FIELD_W; x++) begin
        bank_d[0][IW'(int'(row_q) * FIELD_W + x)] = 1'b0;
        bank_d[1][IW'(int'(row_q) * FIELD_W + x)] = 1'b0;
      end
    end else if (i_is_simulating) begin
      if (in_range(int'(i_cur_x), int'(i_cur_y)))
        bank_d[~i_cur_read_field][IW'(int'(i_cur_y) * FIELD_W + int'(i_cur_x))] =
          i_new_cur_cell_state;
    end else if (i_load_we) begin
      if (in_range(int'(i_load_x), int'(i_load_y)))
        bank_d[i_cur_read_field][IW'(int'(i_load_y) * FIELD_W + int'(i_load_x))] =
          i_load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q  <= '0;
      state_q <= IDLE;
      row_q   <= '0;
      busy_q  <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      disp_q <= cell_at(bank_q[i_cur_read_field], int'(i_disp_x), int'(i_disp_y));
      case (state_q)
        IDLE: if (i_clear) begin
          state_q <= CLEARING;
          busy_q  <= 1'b1;
          row_q   <= '0;
        end
        CLEARING: begin
          if (row_q == Y_ADR_SIZE'(FIELD_H - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            row_q   <= '0;
          end else begin
            row_q <= row_q + Y_ADR_SIZE'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_disp_cell = disp_q;
endmodule

// File: tb/tb_field_mem.sv
// Self-checking bench for field_mem: directed scenarios plus randomized
// traffic compared against an array model of both banks.
module tb_field_mem;
  localparam int W = 5;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cur_read_field, i_is_simulating, i_new_cur_cell_state;
  logic [2:0] i_cur_x, i_next_x, i_load_x, i_disp_x;
  logic [1:0] i_cur_y, i_next_y, i_load_y, i_disp_y;
  logic       o_next_cell_state, i_load_we, i_load_val, o_disp_cell, i_clear, o_busy;
  logic [7:0] o_next_nbrs;

  int checks = 0;
  int passes = 0;
  bit mdl [2][H][W];

  always #5 clk = ~clk;

  field_mem #(.FIELD_W(W), .FIELD_H(H)) dut (
    .clk(clk), .rst(rst),
    .i_cur_read_field(i_cur_read_field), .i_is_simulating(i_is_simulating),
    .i_cur_x(i_cur_x), .i_cur_y(i_cur_y), .i_new_cur_cell_state(i_new_cur_cell_state),
    .i_next_x(i_next_x), .i_next_y(i_next_y),
    .o_next_cell_state(o_next_cell_state), .o_next_nbrs(o_next_nbrs),
    .i_load_we(i_load_we), .i_load_x(i_load_x), .i_load_y(i_load_y), .i_load_val(i_load_val),
    .i_disp_x(i_disp_x), .i_disp_y(i_disp_y), .o_disp_cell(o_disp_cell),
    .i_clear(i_clear), .o_busy(o_busy)
  );

  function automatic bit mcell(int b, int x, int y);
    if (x >= W || y >= H) return 1'b0;
    return mdl[b][y][x];
  endfunction

  // Neighbours enumerated row by row, left to right, skipping the centre.
  function automatic logic [7:0] mnbrs(int b, int x, int y);
    logic [7:0] r;
    int k;
    r = '0;
    k = 0;
    if (x >= W || y >= H) return r;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) begin
          r[k] = mdl[b][(y + dy + H) % H][(x + dx + W) % W];
          k++;
        end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int b, input int x, input int y, input bit v);
    i_cur_read_field = b[0];
    i_load_x = x[2:0]; i_load_y = y[1:0]; i_load_val = v; i_load_we = 1'b1;
    step();
    i_load_we = 1'b0;
    if (x < W && y < H) mdl[b][y][x] = v;
  endtask

  task automatic model_zero();
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) mdl[b][y][x] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_zero();
    checks++;
    if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else passes++;
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          i_cur_read_field = b[0];
          i_next_x = x[2:0]; i_next_y = y[1:0]; i_disp_x = x[2:0]; i_disp_y = y[1:0];
          @(negedge clk);
          checks++;
          if (o_next_cell_state !== 1'b0 || o_next_nbrs !== 8'h00)
            $display("FAIL reset_lookup b%0d (%0d,%0d) got=%b/%h exp=0/00", b, x, y,
                     o_next_cell_state, o_next_nbrs);
          else passes++;
          @(negedge clk);
          checks++;
          if (o_disp_cell !== 1'b0)
            $display("FAIL reset_disp (%0d,%0d) got=%b exp=0", x, y, o_disp_cell);
          else passes++;
          #1;
        end
  endtask

  task automatic test_single_cell();
    do_load(0, 0, 0, 1'b1);
    i_cur_read_field = 1'b0;
    i_next_x = 3'd4; i_next_y = 2'd2;
    @(negedge clk);
    checks++;
    if (o_next_nbrs !== 8'h80) $display("FAIL wrap_nbrs got=%h exp=80", o_next_nbrs); else passes++;
    i_next_x = 3'd1; i_next_y = 2'd1;
    @(negedge clk);
    checks++;
    if (o_next_nbrs !== 8'h01) $display("FAIL diag_nbrs got=%h exp=01", o_next_nbrs); else passes++;
    i_next_x = 3'd0; i_next_y = 2'd0;
    @(negedge clk);
    checks++;
    if (o_next_cell_state !== 1'b1 || o_next_nbrs !== 8'h00)
      $display("FAIL centre got=%b/%h exp=1/00", o_next_cell_state, o_next_nbrs);
    else passes++;
    #1;
  endtask

  task automatic test_sim_write();
    i_cur_read_field = 1'b0;
    i_is_simulating = 1'b1; i_cur_x = 3'd2; i_cur_y = 2'd1; i_new_cur_cell_state = 1'b1;
    step();
    i_is_simulating = 1'b0;
    mdl[1][1][2] = 1'b1;
    i_next_x = 3'd2; i_next_y = 2'd1;
    @(negedge clk);
    checks++;
    if (o_next_cell_state !== 1'b0)
      $display("FAIL sim_readbank_untouched got=%b exp=0", o_next_cell_state);
    else passes++;
    i_cur_read_field = 1'b1;
    #1;
    checks++;
    if (o_next_cell_state !== 1'b1)
      $display("FAIL sim_writebank got=%b exp=1", o_next_cell_state);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    i_cur_read_field = 1'b0;
    i_load_we = 1'b1; i_load_x = 3'd3; i_load_y = 2'd0; i_load_val = 1'b1;
    i_is_simulating = 1'b1; i_cur_x = 3'd3; i_cur_y = 2'd0; i_new_cur_cell_state = 1'b0;
    step();
    i_load_we = 1'b0; i_is_simulating = 1'b0;
    mdl[1][0][3] = 1'b0;
    i_next_x = 3'd3; i_next_y = 2'd0;
    @(negedge clk);
    checks++;
    if (o_next_cell_state !== 1'b0)
      $display("FAIL collision_readbank got=%b exp=0", o_next_cell_state);
    else passes++;
    i_cur_read_field = 1'b1;
    #1;
    checks++;
    if (o_next_cell_state !== 1'b0)
      $display("FAIL collision_writebank got=%b exp=0", o_next_cell_state);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    int cnt;
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) do_load(b, x, y, 1'b1);
    i_cur_read_field = 1'b0; i_next_x = 3'd2; i_next_y = 2'd1;
    @(negedge clk);
    checks++;
    if (o_next_cell_state !== 1'b1 || o_next_nbrs !== 8'hff)
      $display("FAIL full_field got=%b/%h exp=1/ff", o_next_cell_state, o_next_nbrs);
    else passes++;
    #1;
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!o_busy) break;
      cnt++;
      if (c == 0) begin
        i_clear = 1'b1;
        i_load_we = 1'b1; i_load_x = 3'd1; i_load_y = 2'd1; i_load_val = 1'b1;
      end
      if (c == 1) i_clear = 1'b0;
      if (c == 2) i_load_we = 1'b0;
    end
    i_clear = 1'b0; i_load_we = 1'b0;
    checks++;
    if (cnt != H) $display("FAIL busy_cycles got=%0d exp=%0d", cnt, H); else passes++;
    model_zero();
    #1;
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          i_cur_read_field = b[0]; i_next_x = x[2:0]; i_next_y = y[1:0];
          #1;
          checks++;
          if (o_next_cell_state !== 1'b0 || o_next_nbrs !== 8'h00)
            $display("FAIL cleared b%0d (%0d,%0d) got=%b/%h exp=0/00", b, x, y,
                     o_next_cell_state, o_next_nbrs);
          else passes++;
        end
    step();
    checks++;
    if (o_busy !== 1'b0) $display("FAIL busy_after_clear got=%b exp=0", o_busy); else passes++;
  endtask

  task automatic test_reset_midclear();
    do_load(0, 2, 2, 1'b1);
    do_load(1, 4, 2, 1'b1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_zero();
    checks++;
    if (o_busy !== 1'b0) $display("FAIL midclear_busy got=%b exp=0", o_busy); else passes++;
    i_cur_read_field = 1'b0; i_next_x = 3'd2; i_next_y = 2'd2;
    #1;
    checks++;
    if (o_next_cell_state !== 1'b0)
      $display("FAIL midclear_a got=%b exp=0", o_next_cell_state);
    else passes++;
    i_cur_read_field = 1'b1; i_next_x = 3'd4;
    #1;
    checks++;
    if (o_next_cell_state !== 1'b0)
      $display("FAIL midclear_b got=%b exp=0", o_next_cell_state);
    else passes++;
    step();
  endtask

  task automatic test_display();
    do_load(0, 4, 1, 1'b1);
    i_cur_read_field = 1'b0;
    i_disp_x = 3'd0; i_disp_y = 2'd0;
    step();
    i_disp_x = 3'd4; i_disp_y = 2'd1;
    @(negedge clk);
    checks++;
    if (o_disp_cell !== 1'b0) $display("FAIL disp_same_cycle got=%b exp=0", o_disp_cell); else passes++;
    @(negedge clk);
    checks++;
    if (o_disp_cell !== 1'b1) $display("FAIL disp_next_cycle got=%b exp=1", o_disp_cell); else passes++;
    #1;
  endtask

  task automatic test_random();
    bit exp_disp;
    bit have_disp;
    int sel, cx, cy, lx, ly, nx, ny, dx, dy;
    bit sim, lwe, sv, lv;
    have_disp = 1'b0;
    exp_disp = 1'b0;
    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(1); sim = $urandom_range(3) == 0; lwe = $urandom_range(1) == 1;
      cx = $urandom_range(7); cy = $urandom_range(3); sv = $urandom_range(1) == 1;
      lx = $urandom_range(7); ly = $urandom_range(3); lv = $urandom_range(1) == 1;
      nx = $urandom_range(7); ny = $urandom_range(3);
      dx = $urandom_range(7); dy = $urandom_range(3);
      i_cur_read_field = sel[0]; i_is_simulating = sim; i_load_we = lwe;
      i_cur_x = cx[2:0]; i_cur_y = cy[1:0]; i_new_cur_cell_state = sv;
      i_load_x = lx[2:0]; i_load_y = ly[1:0]; i_load_val = lv;
      i_next_x = nx[2:0]; i_next_y = ny[1:0]; i_disp_x = dx[2:0]; i_disp_y = dy[1:0];
      @(negedge clk);
      checks++;
      if (o_next_cell_state !== mcell(sel, nx, ny) || o_next_nbrs !== mnbrs(sel, nx, ny))
        $display("FAIL rand_lookup it%0d b%0d (%0d,%0d) got=%b/%h exp=%b/%h", it, sel, nx, ny,
                 o_next_cell_state, o_next_nbrs, mcell(sel, nx, ny), mnbrs(sel, nx, ny));
      else passes++;
      if (have_disp) begin
        checks++;
        if (o_disp_cell !== exp_disp)
          $display("FAIL rand_disp it%0d got=%b exp=%b", it, o_disp_cell, exp_disp);
        else passes++;
      end
      exp_disp = mcell(sel, dx, dy);
      have_disp = 1'b1;
      if (sim) begin
        if (cx < W && cy < H) mdl[1 - sel][cy][cx] = sv;
      end else if (lwe) begin
        if (lx < W && ly < H) mdl[sel][ly][lx] = lv;
      end
      step();
    end
    i_is_simulating = 1'b0; i_load_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_cur_read_field = 1'b0; i_is_simulating = 1'b0; i_new_cur_cell_state = 1'b0;
    i_cur_x = '0; i_cur_y = '0; i_next_x = '0; i_next_y = '0;
    i_load_we = 1'b0; i_load_x = '0; i_load_y = '0; i_load_val = 1'b0;
    i_disp_x = '0; i_disp_y = '0; i_clear = 1'b0;
    test_reset();
    test_single_cell();
    test_sim_write();
    test_collision();
    test_clear();
    test_reset_midclear();
    test_display();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
